// File: rtl/udp_pingpong_buf_ctrl_if.sv
// Bus bundle for the UDP ping-pong buffer controller: receive stream, RAM write/read
// addressing, consumer handshake and drop counter.
interface udp_pingpong_buf_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              rx_en;
    logic [DATA_W-1:0] rx_data;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_avail;
    logic [ADDR_W:0]   rd_len;
    logic              rd_start;
    logic              rd_ready;
    logic              rd_en;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;
    logic [15:0]       drop_cnt;

    modport slave (
        input  rx_en, rx_data, rd_start, rd_ready,
        output wr_en, wr_bank, wr_addr, wr_data, rd_avail, rd_len,
               rd_en, rd_bank, rd_addr, rd_last, drop_cnt
    );

    modport master (
        output rx_en, rx_data, rd_start, rd_ready,
        input  wr_en, wr_bank, wr_addr, wr_data, rd_avail, rd_len,
               rd_en, rd_bank, rd_addr, rd_last, drop_cnt
    );
endinterface

// File: rtl/udp_pingpong_buf_ctrl.sv
// Ping-pong controller for the UDP receive buffer: fills two RAM banks frame by frame and
// drains them in write order. Optional drop counter built when UDP_BUF_DROP_CNT_EN is defined.
module udp_pingpong_buf_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    RST,
    udp_pingpong_buf_ctrl_if.slave  bus
);
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_RUN  = 2'd1;
    localparam logic [1:0] W_DROP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RUN  = 1'b1;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]              w_state_q, w_state_d;
    logic                    wr_bank_q, wr_bank_d;
    logic [ADDR_W:0]         wr_cnt_q, wr_cnt_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]       wr_data_q, wr_data_d;
    logic [1:0]              full_q, full_d;
    logic [1:0][ADDR_W:0]    len_q, len_d;
    logic [0:0]              r_state_q, r_state_d;
    logic                    rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic                    set_full, clr_full, drop_inc;
    logic                    rd_avail, rd_en, rd_last;
    logic [ADDR_W:0]         rd_len;

    always_comb begin
        w_state_d = w_state_q;
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        set_full  = 1'b0;
        drop_inc  = 1'b0;
        case (w_state_q)
            W_IDLE: if (bus.rx_en) begin
                if (full_q[wr_bank_q]) begin
                    w_state_d = W_DROP;
                    drop_inc  = 1'b1;
                end else begin
                    w_state_d = W_RUN;
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = bus.rx_data;
                    wr_cnt_d  = (ADDR_W+1)'(1);
                end
            end
            W_RUN: if (bus.rx_en) begin
                // Bank is full at DEPTH words: extra words are swallowed, never wrapped to 0.
                if (wr_cnt_q != DEPTH) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_cnt_q[ADDR_W-1:0];
                    wr_data_d = bus.rx_data;
                    wr_cnt_d  = wr_cnt_q + 1'b1;
                end
            end else begin
                set_full  = 1'b1;
                wr_bank_d = ~wr_bank_q;
                w_state_d = W_IDLE;
            end
            W_DROP: if (!bus.rx_en) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    assign rd_len   = len_q[rd_bank_q];
    assign rd_avail = full_q[rd_bank_q] & (r_state_q == R_IDLE);
    assign rd_en    = (r_state_q == R_RUN) & bus.rd_ready;
    assign rd_last  = rd_en & ({1'b0, rd_addr_q} == (rd_len - (ADDR_W+1)'(1)));

    always_comb begin
        r_state_d = r_state_q;
        rd_bank_d = rd_bank_q;
        rd_addr_d = rd_addr_q;
        clr_full  = 1'b0;
        case (r_state_q)
            R_IDLE: if (bus.rd_start && rd_avail) begin
                r_state_d = R_RUN;
                rd_addr_d = '0;
            end
            default: if (rd_en) begin
                if (rd_last) begin
                    clr_full  = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    rd_addr_d = '0;
                    r_state_d = R_IDLE;
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
        endcase
    end

    // Set and clear always target different banks, so both apply on the same edge.
    always_comb begin
        full_d = full_q;
        len_d  = len_q;
        if (set_full) begin
            full_d[wr_bank_q] = 1'b1;
            len_d[wr_bank_q]  = wr_cnt_q;
        end
        if (clr_full) full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            w_state_q <= W_IDLE;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            full_q    <= '0;
            len_q     <= '0;
            r_state_q <= R_IDLE;
            rd_bank_q <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            w_state_q <= w_state_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            full_q    <= full_d;
            len_q     <= len_d;
            r_state_q <= r_state_d;
            rd_bank_q <= rd_bank_d;
            rd_addr_q <= rd_addr_d;
        end
    end

`ifdef UDP_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt_q;
    always_ff @(posedge clk) begin
        if (RST)                                  drop_cnt_q <= '0;
        else if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
    assign bus.drop_cnt = drop_cnt_q;
`else
    logic unused_drop_inc;
    assign unused_drop_inc = drop_inc;
    assign bus.drop_cnt    = 16'd0;
`endif

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_bank  = wr_bank_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.rd_avail = rd_avail;
    assign bus.rd_len   = rd_len;
    assign bus.rd_en    = rd_en;
    assign bus.rd_bank  = rd_bank_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.rd_last  = rd_last;
endmodule

// File: tb/tb_udp_pingpong_buf_ctrl.sv
// Self-checking bench for udp_pingpong_buf_ctrl (ADDR_W=4): operation table plus
// hand-written concurrency and reset sequences, with write/read scoreboards.
module tb_udp_pingpong_buf_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    udp_pingpong_buf_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    udp_pingpong_buf_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .RST(RST), .bus(bus));

    typedef struct {
        logic          bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        bit          is_drain;
        int          n;
        logic [31:0] base;
        logic [7:0]  pat;
        int          exp_len;
        bit          exp_bank;
    } op_t;

    exp_t exp_wr[$];
    exp_t exp_rd[$];
    int   checks = 0;
    int   errors = 0;

    bit   m_full[2];
    int   m_len[2];
    bit   m_wr, m_rd;
    int   m_drop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_drop();
`ifdef UDP_BUF_DROP_CNT_EN
        return m_drop;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.wr_en) begin
            if (exp_wr.size() == 0) chk("wr_unexpected", bus.wr_en, 1'b0);
            else begin
                e = exp_wr.pop_front();
                chk("wr_bank", bus.wr_bank, e.bank);
                chk("wr_addr", bus.wr_addr, e.addr);
                chk("wr_data", bus.wr_data, e.data);
            end
        end
        if (bus.rd_en) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", bus.rd_en, 1'b0);
            else begin
                e = exp_rd.pop_front();
                chk("rd_bank", bus.rd_bank, e.bank);
                chk("rd_addr", bus.rd_addr, e.addr);
                chk("rd_last", bus.rd_last, e.last);
            end
        end
    end

    // All tasks start and end at posedge+1.
    task automatic send_frame(input int n, input logic [31:0] base);
        exp_t e;
        bit acc = !m_full[m_wr];
        bit b   = m_wr;
        int nw  = (n > DEPTH) ? DEPTH : n;
        if (acc) begin
            for (int i = 0; i < nw; i++) begin
                e.bank = b; e.addr = AW'(i); e.data = base + i; e.last = 1'b0;
                exp_wr.push_back(e);
            end
        end else if (m_drop < 65535) m_drop++;
        for (int i = 0; i < n; i++) begin
            bus.rx_en = 1'b1; bus.rx_data = base + i;
            @(posedge clk); #1;
        end
        bus.rx_en = 1'b0; bus.rx_data = '0;
        @(posedge clk); #1;
        if (acc) begin
            m_full[b] = 1'b1; m_len[b] = nw; m_wr = ~m_wr;
        end
        chk("drop_cnt", bus.drop_cnt, exp_drop());
    endtask

    task automatic drain(input logic [7:0] pat, input int exp_len, input bit exp_bank, input bit chk_after);
        exp_t e;
        bit b     = m_rd;
        int len   = m_len[b];
        int k = 0, c = 0, exp_cyc, cyc;
        bit done  = 1'b0;
        chk("rd_avail", bus.rd_avail, 1'b1);
        chk("rd_len", bus.rd_len, exp_len);
        chk("rd_bank_sel", bus.rd_bank, exp_bank);
        for (int i = 0; i < len; i++) begin
            e.bank = b; e.addr = AW'(i); e.data = '0; e.last = (i == len - 1);
            exp_rd.push_back(e);
        end
        while (k < len) begin
            if (pat[c % 8]) k++;
            c++;
        end
        exp_cyc = 1 + c;
        bus.rd_start = 1'b1; bus.rd_ready = 1'b0;
        @(posedge clk); #1;
        bus.rd_start = 1'b0;
        cyc = 1; c = 0;
        while (!done && cyc < 300) begin
            bus.rd_ready = pat[c % 8];
            @(negedge clk);
            if (bus.rd_en && bus.rd_last) done = 1'b1;
            @(posedge clk); #1;
            c++; cyc++;
        end
        bus.rd_ready = 1'b0;
        chk("drain_done", done, 1'b1);
        chk("drain_cycles", cyc, exp_cyc);
        m_full[b] = 1'b0; m_rd = ~m_rd;
        chk("rd_bank_after", bus.rd_bank, m_rd);
        if (chk_after) chk("rd_avail_after", bus.rd_avail, m_full[m_rd]);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"},   bus.wr_en,    1'b0);
        chk({tag, "_wr_bank"}, bus.wr_bank,  1'b0);
        chk({tag, "_wr_addr"}, bus.wr_addr,  '0);
        chk({tag, "_wr_data"}, bus.wr_data,  '0);
        chk({tag, "_rd_avail"},bus.rd_avail, 1'b0);
        chk({tag, "_rd_len"},  bus.rd_len,   '0);
        chk({tag, "_rd_en"},   bus.rd_en,    1'b0);
        chk({tag, "_rd_bank"}, bus.rd_bank,  1'b0);
        chk({tag, "_rd_addr"}, bus.rd_addr,  '0);
        chk({tag, "_rd_last"}, bus.rd_last,  1'b0);
        chk({tag, "_drop"},    bus.drop_cnt, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        op_t ops[11];
        ops[0]  = '{0,  8, 32'h1,   8'h00, 0,  0};
        ops[1]  = '{1,  0, 32'h0,   8'hFF, 8,  0};
        ops[2]  = '{0,  5, 32'h100, 8'h00, 0,  0};
        ops[3]  = '{0,  3, 32'h200, 8'h00, 0,  0};
        ops[4]  = '{0,  4, 32'h300, 8'h00, 0,  0};  // both banks full: dropped
        ops[5]  = '{1,  0, 32'h0,   8'hFF, 5,  1};
        ops[6]  = '{1,  0, 32'h0,   8'hFF, 3,  0};
        ops[7]  = '{0,  4, 32'h400, 8'h00, 0,  0};
        ops[8]  = '{1,  0, 32'h0,   8'h55, 4,  1};  // ready 1,0,1,0...
        ops[9]  = '{0, 20, 32'h500, 8'h00, 0,  0};  // clamps at 16 words
        ops[10] = '{1,  0, 32'h0,   8'hFF, 16, 0};

        m_full = '{0, 0}; m_len = '{0, 0}; m_wr = 0; m_rd = 0; m_drop = 0;
        RST = 1'b1;
        bus.rx_en = 1'b0; bus.rx_data = '0; bus.rd_start = 1'b0; bus.rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        RST = 1'b0;
        @(posedge clk); #1;

        foreach (ops[i]) begin
            if (ops[i].is_drain) drain(ops[i].pat, ops[i].exp_len, ops[i].exp_bank, 1'b1);
            else                 send_frame(ops[i].n, ops[i].base);
        end

        // Write set-full and read clear-empty land on the same edge.
        send_frame(4, 32'h600);
        fork
            drain(8'hFF, 4, 1'b1, 1'b0);
            send_frame(4, 32'h700);
        join
        drain(8'hFF, 4, 1'b0, 1'b1);

        // Bank freed on edge N accepts a frame starting at edge N+1.
        send_frame(3, 32'h800);
        send_frame(2, 32'h900);
        drain(8'hFF, 3, 1'b1, 1'b1);
        send_frame(2, 32'hA00);
        chk("no_drop_after_free", bus.drop_cnt, exp_drop());
        drain(8'hFF, 2, 1'b0, 1'b1);
        drain(8'hFF, 2, 1'b1, 1'b1);

        // Reset mid-frame with the other bank holding a full frame.
        send_frame(2, 32'hB00);
        begin
            exp_t e;
            for (int i = 0; i < 3; i++) begin
                e.bank = 1'b1; e.addr = AW'(i); e.data = 32'hC00 + i; e.last = 1'b0;
                exp_wr.push_back(e);
            end
            for (int i = 0; i < 3; i++) begin
                bus.rx_en = 1'b1; bus.rx_data = 32'hC00 + i;
                @(posedge clk); #1;
            end
        end
        RST = 1'b1; bus.rx_data = 32'hC03;
        @(posedge clk); #1;
        chk_zero("midreset");
        bus.rx_en = 1'b0; bus.rx_data = '0;
        @(posedge clk); #1;
        RST = 1'b0;
        m_full = '{0, 0}; m_len = '{0, 0}; m_wr = 0; m_rd = 0; m_drop = 0;
        bus.rd_start = 1'b1; bus.rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_reset_avail", bus.rd_avail, 1'b0);
        end
        bus.rd_start = 1'b0; bus.rd_ready = 1'b0;
        send_frame(2, 32'hD00);
        drain(8'hFF, 2, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
